// File: rtl/rvfi_retire_buffer_if.sv
// RVFI retire buffer bus: multi-channel retirement inputs, single-entry drain port and status.
// Optional out_cycle appears when RVFI_RETIRE_CYCLE_EN is defined.
interface rvfi_retire_buffer_if #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NRET-1:0]      in_valid;
  logic [64*NRET-1:0]   in_order;
  logic [32*NRET-1:0]   in_insn;
  logic [NRET-1:0]      in_trap;
  logic [XLEN*NRET-1:0] in_pc_rdata;
  logic [XLEN*NRET-1:0] in_pc_wdata;
  logic [5*NRET-1:0]    in_rd_addr;
  logic [XLEN*NRET-1:0] in_rd_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_order;
  logic [31:0]          out_insn;
  logic                 out_trap;
  logic [XLEN-1:0]      out_pc_rdata;
  logic [XLEN-1:0]      out_pc_wdata;
  logic [4:0]           out_rd_addr;
  logic [XLEN-1:0]      out_rd_wdata;
  logic [LW-1:0]        level;
  logic                 err_overflow;
  logic                 err_order;
  logic                 err_pack;
`ifdef RVFI_RETIRE_CYCLE_EN
  logic [31:0]          out_cycle;

  modport master (
    output in_valid, in_order, in_insn, in_trap, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata, out_ready,
    input  out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
           level, err_overflow, err_order, err_pack, out_cycle
  );
  modport slave (
    input  in_valid, in_order, in_insn, in_trap, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata, out_ready,
    output out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
           level, err_overflow, err_order, err_pack, out_cycle
  );
`else
  modport master (
    output in_valid, in_order, in_insn, in_trap, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata, out_ready,
    input  out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
           level, err_overflow, err_order, err_pack
  );
  modport slave (
    input  in_valid, in_order, in_insn, in_trap, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata, out_ready,
    output out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
           level, err_overflow, err_order, err_pack
  );
`endif
endinterface

// File: rtl/rvfi_retire_buffer.sv
// Captures up to NRET RVFI retirements per cycle into a circular FIFO and drains one per cycle,
// checking order continuity and channel packing. RVFI_RETIRE_CYCLE_EN adds per-entry cycle stamps.
module rvfi_retire_buffer #(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic                clock,
  input logic                reset_n,
  rvfi_retire_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 3;

  logic [63:0]      r_order [DEPTH];
  logic [31:0]      r_insn  [DEPTH];
  logic [DEPTH-1:0] r_trap;
  logic [XLEN-1:0]  r_pcr   [DEPTH];
  logic [XLEN-1:0]  r_pcw   [DEPTH];
  logic [4:0]       r_rda   [DEPTH];
  logic [XLEN-1:0]  r_rdw   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [63:0]      r_exp_order;
  logic             r_err_overflow;
  logic             r_err_order;
  logic             r_err_pack;
`ifdef RVFI_RETIRE_CYCLE_EN
  logic [31:0]      r_cycle;
  logic [31:0]      r_stamp [DEPTH];
`endif

  logic [CW-1:0]    w_n;
  logic [AW-1:0]    w_slot [NRET];
  logic             w_mis;
  logic [63:0]      w_last;
  logic             w_pop;
  logic [LW:0]      w_fill;
  logic             w_accept;
  logic             w_drop;
  logic             w_pack_bad;

  // Rank valid channels, assign FIFO slots and check order continuity against the expected order.
  always_comb begin
    w_n    = {CW{1'b0}};
    w_mis  = 1'b0;
    w_last = r_exp_order;
    for (int k = 0; k < NRET; k++) begin
      w_slot[k] = r_wr_ptr + AW'(w_n);
      if (bus.in_valid[k]) begin
        w_mis  = w_mis | (bus.in_order[64*k +: 64] != r_exp_order + 64'(w_n));
        w_last = bus.in_order[64*k +: 64];
        w_n    = w_n + 3'd1;
      end else begin
        w_n    = w_n;
      end
    end
  end

  // Space test counts a same-cycle pop as freeing its slot.
  assign w_pop      = (r_level != {LW{1'b0}}) && bus.out_ready;
  assign w_fill     = {1'b0, r_level} - {{LW{1'b0}}, w_pop} + (LW+1)'(w_n);
  assign w_accept   = (w_n != {CW{1'b0}}) && (w_fill <= (LW+1)'(DEPTH));
  assign w_drop     = (w_n != {CW{1'b0}}) && !w_accept;
  assign w_pack_bad = |(bus.in_valid & (bus.in_valid + NRET'(1)));

  // Pointers, occupancy, expected order and sticky error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= {AW{1'b0}};
      r_rd_ptr       <= {AW{1'b0}};
      r_level        <= {LW{1'b0}};
      r_exp_order    <= 64'd0;
      r_err_overflow <= 1'b0;
      r_err_order    <= 1'b0;
      r_err_pack     <= 1'b0;
    end else begin
      r_wr_ptr       <= w_accept ? r_wr_ptr + AW'(w_n) : r_wr_ptr;
      r_rd_ptr       <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_level        <= r_level + (w_accept ? LW'(w_n) : {LW{1'b0}}) - LW'(w_pop);
      r_exp_order    <= w_accept ? w_last + 64'd1 : r_exp_order;
      r_err_overflow <= r_err_overflow | w_drop;
      r_err_order    <= r_err_order | (w_accept & w_mis);
      r_err_pack     <= r_err_pack | w_pack_bad;
    end
  end

  // Entry storage; cleared on reset so an empty FIFO presents zero data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_trap <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_order[i] <= 64'd0;
        r_insn[i]  <= 32'd0;
        r_pcr[i]   <= {XLEN{1'b0}};
        r_pcw[i]   <= {XLEN{1'b0}};
        r_rda[i]   <= 5'd0;
        r_rdw[i]   <= {XLEN{1'b0}};
`ifdef RVFI_RETIRE_CYCLE_EN
        r_stamp[i] <= 32'd0;
`endif
      end
`ifdef RVFI_RETIRE_CYCLE_EN
      r_cycle <= 32'd0;
`endif
    end else begin
`ifdef RVFI_RETIRE_CYCLE_EN
      r_cycle <= r_cycle + 32'd1;
`endif
      for (int k = 0; k < NRET; k++) begin
        if (w_accept && bus.in_valid[k]) begin
          r_order[w_slot[k]] <= bus.in_order[64*k +: 64];
          r_insn[w_slot[k]]  <= bus.in_insn[32*k +: 32];
          r_trap[w_slot[k]]  <= bus.in_trap[k];
          r_pcr[w_slot[k]]   <= bus.in_pc_rdata[XLEN*k +: XLEN];
          r_pcw[w_slot[k]]   <= bus.in_pc_wdata[XLEN*k +: XLEN];
          r_rda[w_slot[k]]   <= bus.in_rd_addr[5*k +: 5];
          r_rdw[w_slot[k]]   <= bus.in_rd_wdata[XLEN*k +: XLEN];
`ifdef RVFI_RETIRE_CYCLE_EN
          r_stamp[w_slot[k]] <= r_cycle;
`endif
        end
      end
    end
  end

  assign bus.out_valid    = (r_level != {LW{1'b0}});
  assign bus.out_order    = r_order[r_rd_ptr];
  assign bus.out_insn     = r_insn[r_rd_ptr];
  assign bus.out_trap     = r_trap[r_rd_ptr];
  assign bus.out_pc_rdata = r_pcr[r_rd_ptr];
  assign bus.out_pc_wdata = r_pcw[r_rd_ptr];
  assign bus.out_rd_addr  = r_rda[r_rd_ptr];
  assign bus.out_rd_wdata = (r_rda[r_rd_ptr] == 5'd0) ? {XLEN{1'b0}} : r_rdw[r_rd_ptr];
  assign bus.level        = r_level;
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_order    = r_err_order;
  assign bus.err_pack     = r_err_pack;
`ifdef RVFI_RETIRE_CYCLE_EN
  assign bus.out_cycle    = r_stamp[r_rd_ptr];
`endif
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Directed plus randomized bench for rvfi_retire_buffer against a queue-based reference model.
module tb_rvfi_retire_buffer;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  rvfi_retire_buffer_if #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  rvfi_retire_buffer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic            trap;
    logic [XLEN-1:0] pcr;
    logic [XLEN-1:0] pcw;
    logic [4:0]      rda;
    logic [XLEN-1:0] rdw;
    logic [31:0]     cyc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_exp;
  logic        m_ovf, m_ord, m_pack;
  logic [31:0] m_cyc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
    chk("err_order", 64'(bus.err_order), 64'(m_ord));
    chk("err_pack", 64'(bus.err_pack), 64'(m_pack));
    if (q.size() != 0) begin
      chk("out_order", bus.out_order, q[0].order);
      chk("out_insn", 64'(bus.out_insn), 64'(q[0].insn));
      chk("out_trap", 64'(bus.out_trap), 64'(q[0].trap));
      chk("out_pc_rdata", 64'(bus.out_pc_rdata), 64'(q[0].pcr));
      chk("out_pc_wdata", 64'(bus.out_pc_wdata), 64'(q[0].pcw));
      chk("out_rd_addr", 64'(bus.out_rd_addr), 64'(q[0].rda));
      chk("out_rd_wdata", 64'(bus.out_rd_wdata), (q[0].rda == 5'd0) ? 64'd0 : 64'(q[0].rdw));
`ifdef RVFI_RETIRE_CYCLE_EN
      chk("out_cycle", 64'(bus.out_cycle), 64'(q[0].cyc));
`endif
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1, input logic rdy);
    int   n, r;
    bit   pop;
    ent_t e;
    logic [63:0] last;
    bus.in_valid  = v;
    bus.in_order  = {o1, o0};
    bus.out_ready = rdy;
    for (int c = 0; c < NRET; c++) begin
      bus.in_insn[32*c +: 32]       = $urandom;
      bus.in_trap[c]                = 1'($urandom_range(0, 1));
      bus.in_pc_rdata[XLEN*c +: XLEN] = $urandom;
      bus.in_pc_wdata[XLEN*c +: XLEN] = $urandom;
      bus.in_rd_addr[5*c +: 5]      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.in_rd_wdata[XLEN*c +: XLEN] = $urandom;
    end
    n   = $countones(v);
    pop = (q.size() != 0) && rdy;
    if (int'(v) != (1 << n) - 1) m_pack = 1'b1;
    if (n != 0) begin
      if (q.size() - int'(pop) + n <= DEPTH) begin
        r = 0;
        last = m_exp;
        for (int c = 0; c < NRET; c++) begin
          if (v[c]) begin
            e.order = bus.in_order[64*c +: 64];
            e.insn  = bus.in_insn[32*c +: 32];
            e.trap  = bus.in_trap[c];
            e.pcr   = bus.in_pc_rdata[XLEN*c +: XLEN];
            e.pcw   = bus.in_pc_wdata[XLEN*c +: XLEN];
            e.rda   = bus.in_rd_addr[5*c +: 5];
            e.rdw   = bus.in_rd_wdata[XLEN*c +: XLEN];
            e.cyc   = m_cyc;
            if (e.order != m_exp + 64'(r)) m_ord = 1'b1;
            last = e.order;
            r++;
            q.push_back(e);
          end
        end
        m_exp = last + 64'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    m_cyc = m_cyc + 32'd1;
    @(negedge clock);
    check_all();
  endtask

  // Asynchronous reset pulse off the clock edges; returns at a falling edge.
  task automatic do_reset();
    @(posedge clock);
    #2;
    reset_n         = 1'b0;
    bus.in_valid    = '0;
    bus.in_order    = '0;
    bus.in_insn     = '0;
    bus.in_trap     = '0;
    bus.in_pc_rdata = '0;
    bus.in_pc_wdata = '0;
    bus.in_rd_addr  = '0;
    bus.in_rd_wdata = '0;
    bus.out_ready   = 1'b0;
    q.delete();
    m_exp = 64'd0; m_ovf = 1'b0; m_ord = 1'b0; m_pack = 1'b0; m_cyc = 32'd0;
    #1;
    check_all();
    chk("rst_out_order", bus.out_order, 64'd0);
    chk("rst_out_insn", 64'(bus.out_insn), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc_rdata) | 64'(bus.out_pc_wdata), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd_addr) | 64'(bus.out_rd_wdata) | 64'(bus.out_trap), 64'd0);
`ifdef RVFI_RETIRE_CYCLE_EN
    chk("rst_out_cycle", 64'(bus.out_cycle), 64'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0]  v;
    logic [63:0] o0, o1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;

    // Basic pair push then drain.
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, 1'b0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1);
    cyc(2'b00, 64'd0, 64'd0, 1'b1);
    cyc(2'b00, 64'd0, 64'd0, 1'b0);

    // Fill to DEPTH, overflow, then boundary at level 7 and 8 with ready high.
    for (int i = 0; i < 4; i++) cyc(2'b11, 64'(2 + 2*i), 64'(3 + 2*i), 1'b0);
    cyc(2'b11, 64'd10, 64'd11, 1'b0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1);
    cyc(2'b11, 64'd10, 64'd11, 1'b1);
    cyc(2'b11, 64'd12, 64'd13, 1'b1);
    for (int i = 0; i < 8; i++) cyc(2'b00, 64'd0, 64'd0, 1'b1);

    // Order discontinuity and resynchronisation; reset lands with entries still queued.
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, 1'b0);
    cyc(2'b11, 64'd5, 64'd6, 1'b0);
    cyc(2'b11, 64'd7, 64'd8, 1'b0);
    do_reset();

    // Non-contiguous valid pattern stores channel 1 only.
    cyc(2'b10, 64'hdead, 64'd0, 1'b0);
    cyc(2'b00, 64'd0, 64'd0, 1'b1);

    // Continuous streaming across pointer wrap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(2'b11, m_exp, m_exp + 64'd1, 1'b1);
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
    end
    for (int i = 0; i < 20; i++) cyc(2'b01, m_exp, 64'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: v = 2'b00;
        3, 4, 5: v = 2'b01;
        9:       v = 2'b10;
        default: v = 2'b11;
      endcase
      o0 = m_exp;
      o1 = v[0] ? m_exp + 64'd1 : m_exp;
      if ($urandom_range(0, 19) == 0) begin
        o0 = o0 + 64'd3;
        o1 = o1 + 64'd3;
      end
      cyc(v, o0, o1, 1'($urandom_range(0, 2) != 0));
      if (i == 200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
